// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point FFT pipeline: controller state encodings,
// default widths, and the saturate / round-shift helpers used by every stage.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FIRST   = 2'b01,
        ST_SECOND  = 2'b10,
        ST_WAITING = 2'b11
    } fft_state_e;

    localparam int FFT_DW = 14;
    localparam int FFT_WW = 8;
    localparam int FFT_WF = 6;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] sat_val(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            sat_val = hi;
        end else if (v < lo) begin
            sat_val = lo;
        end else begin
            sat_val = v;
        end
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] v, input int w);
        sat_hit = (v != sat_val(v, w));
    endfunction

    // Arithmetic shift right with round-half-up.
    function automatic logic signed [31:0] rnd_shr(input logic signed [31:0] v, input int sh);
        if (sh <= 0) begin
            rnd_shr = v;
        end else begin
            rnd_shr = (v + (32'sd1 <<< (sh - 1))) >>> sh;
        end
    endfunction

endpackage

// File: rtl/cmul_q26.sv
// Combinational complex multiplier: data x Q2.6 twiddle, round-half-up, saturate.
// Reports whether either component clipped.
module cmul_q26
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int WW = FFT_WW,
    parameter int WF = FFT_WF
) (
    input  logic signed [DW-1:0] b_r,
    input  logic signed [DW-1:0] b_i,
    input  logic signed [WW-1:0] w_r,
    input  logic signed [WW-1:0] w_i,
    output logic signed [DW-1:0] p_r,
    output logic signed [DW-1:0] p_i,
    output logic                 sat
);

    logic signed [31:0] re_full_s;
    logic signed [31:0] im_full_s;
    logic signed [31:0] re_rnd_s;
    logic signed [31:0] im_rnd_s;

    // Full-precision products, then rounding and clamping of each component.
    always_comb begin
        re_full_s = 32'(b_r) * 32'(w_r) - 32'(b_i) * 32'(w_i);
        im_full_s = 32'(b_r) * 32'(w_i) + 32'(b_i) * 32'(w_r);
        re_rnd_s  = rnd_shr(re_full_s, WF);
        im_rnd_s  = rnd_shr(im_full_s, WF);
        p_r       = DW'(sat_val(re_rnd_s, DW));
        p_i       = DW'(sat_val(im_rnd_s, DW));
        sat       = sat_hit(re_rnd_s, DW) | sat_hit(im_rnd_s, DW);
    end

endmodule

// File: rtl/sdf_bf_stage8.sv
// Radix-2 SDF butterfly stage with an 8-deep complex feedback delay line.
// Define SDF_STAGE_SCALE_EN to halve (round-half-up) the butterfly outputs.
module sdf_bf_stage8
    import fft_pkg::*;
#(
    parameter int DW    = FFT_DW,
    parameter int WW    = FFT_WW,
    parameter int WF    = FFT_WF,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [1:0]           state_i,
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [WW-1:0] wn_r,
    input  logic signed [WW-1:0] wn_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] y_r,
    output logic signed [DW-1:0] y_i,
    output logic                 sat_o
);

    logic signed [DW-1:0] dl_re_r [DEPTH];
    logic signed [DW-1:0] dl_im_r [DEPTH];
    logic [1:0]           state_prev_r;

    logic signed [DW-1:0] b_re_s, b_im_s;
    logic signed [DW:0]   g_re_s, g_im_s, h_re_s, h_im_s;
    logic signed [31:0]   g_sc_re_s, g_sc_im_s, h_sc_re_s, h_sc_im_s;
    logic signed [DW-1:0] mul_re_s, mul_im_s;
    logic                 mul_sat_s;
    logic signed [DW-1:0] push_re_s, push_im_s;
    logic signed [DW-1:0] y_re_s, y_im_s;
    logic                 sat_hit_s;
    logic                 valid_nxt_s;
    logic                 frame_start_s;

    cmul_q26 #(
        .DW (DW),
        .WW (WW),
        .WF (WF)
    ) u_cmul (
        .b_r (b_re_s),
        .b_i (b_im_s),
        .w_r (wn_r),
        .w_i (wn_i),
        .p_r (mul_re_s),
        .p_i (mul_im_s),
        .sat (mul_sat_s)
    );

    // Butterfly on the delay-line tail B and port A, one extra bit of headroom.
    always_comb begin
        b_re_s = dl_re_r[DEPTH-1];
        b_im_s = dl_im_r[DEPTH-1];
        g_re_s = {b_re_s[DW-1], b_re_s} + {a_r[DW-1], a_r};
        g_im_s = {b_im_s[DW-1], b_im_s} + {a_i[DW-1], a_i};
        h_re_s = {b_re_s[DW-1], b_re_s} - {a_r[DW-1], a_r};
        h_im_s = {b_im_s[DW-1], b_im_s} - {a_i[DW-1], a_i};
`ifdef SDF_STAGE_SCALE_EN
        g_sc_re_s = rnd_shr(32'(g_re_s), 32'sd1);
        g_sc_im_s = rnd_shr(32'(g_im_s), 32'sd1);
        h_sc_re_s = rnd_shr(32'(h_re_s), 32'sd1);
        h_sc_im_s = rnd_shr(32'(h_im_s), 32'sd1);
`else
        g_sc_re_s = 32'(g_re_s);
        g_sc_im_s = 32'(g_im_s);
        h_sc_re_s = 32'(h_re_s);
        h_sc_im_s = 32'(h_im_s);
`endif
    end

    // Per-state selection of the pushed sample, the next output and saturation.
    always_comb begin
        push_re_s = a_r;
        push_im_s = a_i;
        y_re_s    = {DW{1'b0}};
        y_im_s    = {DW{1'b0}};
        sat_hit_s = 1'b0;
        case (state_i)
            ST_FIRST: begin
                push_re_s = DW'(sat_val(h_sc_re_s, DW));
                push_im_s = DW'(sat_val(h_sc_im_s, DW));
                if (valid_i) begin
                    y_re_s = DW'(sat_val(g_sc_re_s, DW));
                    y_im_s = DW'(sat_val(g_sc_im_s, DW));
                end else begin
                    y_re_s = {DW{1'b0}};
                    y_im_s = {DW{1'b0}};
                end
                sat_hit_s = sat_hit(g_sc_re_s, DW) | sat_hit(g_sc_im_s, DW)
                          | sat_hit(h_sc_re_s, DW) | sat_hit(h_sc_im_s, DW);
            end
            ST_SECOND: begin
                if (valid_i) begin
                    y_re_s = mul_re_s;
                    y_im_s = mul_im_s;
                end else begin
                    y_re_s = {DW{1'b0}};
                    y_im_s = {DW{1'b0}};
                end
                sat_hit_s = mul_sat_s;
            end
            ST_WAITING: begin
                sat_hit_s = 1'b0;
            end
            default: begin
                sat_hit_s = 1'b0;
            end
        endcase
        valid_nxt_s   = valid_i & ((state_i == ST_FIRST) | (state_i == ST_SECOND));
        frame_start_s = (state_prev_r == ST_IDLE) & (state_i == ST_WAITING);
    end

    // Feedback delay line: shifts every non-IDLE cycle, holds in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_re_r[i] <= {DW{1'b0}};
                dl_im_r[i] <= {DW{1'b0}};
            end
        end else if (state_i != ST_IDLE) begin
            dl_re_r[0] <= push_re_s;
            dl_im_r[0] <= push_im_s;
            for (int i = 1; i < DEPTH; i++) begin
                dl_re_r[i] <= dl_re_r[i-1];
                dl_im_r[i] <= dl_im_r[i-1];
            end
        end
    end

    // Registered outputs; sat_o is sticky until a new frame leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r          <= {DW{1'b0}};
            y_i          <= {DW{1'b0}};
            valid_o      <= 1'b0;
            sat_o        <= 1'b0;
            state_prev_r <= ST_IDLE;
        end else begin
            y_r          <= y_re_s;
            y_i          <= y_im_s;
            valid_o      <= valid_nxt_s;
            state_prev_r <= state_i;
            if (frame_start_s) begin
                sat_o <= 1'b0;
            end else if (sat_hit_s) begin
                sat_o <= 1'b1;
            end
        end
    end

endmodule
